// File: rtl/mac_feeder_if.sv
// mac_feeder_if: valid/ready stream bundle for the weight, activation and MAC-array ports.
// first/last are only meaningful on the master (array-facing) side.
interface mac_feeder_if #(parameter int W = 8);
   logic [W-1:0] data;
   logic         valid;
   logic         ready;
   logic         first;
   logic         last;
   modport master (output data, valid, first, last, input ready);
   modport slave (input data, valid, output ready);
endinterface

// File: rtl/mac_feeder.sv
// mac_feeder: loads ROW weight vectors, then streams a diagonally skewed activation tile to the MAC array.
// Optional stall_cnt_o output is enabled with `define MAC_FEEDER_STALL_CNT_EN.
module mac_feeder #(
   parameter int DW     = 8,
   parameter int WW     = 8,
   parameter int ROW    = 8,
   parameter int COLUMN = 6,
   parameter int LENW   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_start_i,
   input  logic [LENW-1:0]      cfg_len_i,
   output logic                 busy_o,
   output logic                 done_o,
   mac_feeder_if.slave          wt,
   mac_feeder_if.slave          act,
   mac_feeder_if.master         mac_m,
   output logic [COLUMN*WW-1:0] w_o,
   output logic [COLUMN-1:0]    w_en_o
`ifdef MAC_FEEDER_STALL_CNT_EN
   ,
   output logic [31:0]          stall_cnt_o
`endif
);
   localparam int CW = $clog2(ROW) + 1;
   localparam int BW = LENW + $clog2(ROW) + 1;
   typedef enum logic [2:0] {IDLE, WLOAD, WSETTLE, STREAM, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LENW-1:0] len_q, len_d;
   logic [BW-1:0] nb_q, nb_d, total;
   logic [ROW*DW-1:0] data_q, data_d, vin, beat;
   logic first_q, first_d, last_q, last_d, valid_q, valid_d;
   logic [COLUMN*WW-1:0] w_q, w_d;
   logic [COLUMN-1:0] w_en_q, w_en_d;
   logic in_vec, free, xfer, ld, clr;
   // nb_q counts beats placed in the output register; below len_q each beat consumes one input vector
   assign total = BW'(len_q) + BW'(ROW - 1);
   assign in_vec = nb_q < BW'(len_q);
   assign xfer = valid_q & mac_m.ready;
   assign free = ~valid_q | mac_m.ready;
   assign ld = state_q == STREAM && free && nb_q < total && (!in_vec || act.valid);
   assign clr = state_q == STREAM && xfer && last_q;
   assign vin = in_vec ? act.data : '0;
   assign act.ready = state_q == STREAM && in_vec && free;
   assign wt.ready = state_q == WLOAD;
   assign mac_m.data = data_q;
   assign mac_m.first = first_q;
   assign mac_m.last = last_q;
   assign mac_m.valid = valid_q;
   assign w_o = w_q;
   assign w_en_o = w_en_q;
   assign busy_o = state_q != IDLE;
   assign done_o = state_q == DONE;
   assign beat[DW-1:0] = vin[DW-1:0];
   // lane r delays by r beats; the shift happens only when a new beat is loaded
   for (genvar r = 1; r < ROW; r++) begin : g_lane
      logic [r*DW-1:0] dl_q, dl_d;
      if (r == 1) begin : g_s
         assign dl_d = vin[DW +: DW];
      end else begin : g_m
         assign dl_d = {dl_q[(r-1)*DW-1:0], vin[r*DW +: DW]};
      end
      assign beat[r*DW +: DW] = dl_q[r*DW-1 -: DW];
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) dl_q <= '0;
         else if (clr) dl_q <= '0;
         else if (ld) dl_q <= dl_d;
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      len_d = len_q;
      nb_d = nb_q;
      data_d = data_q;
      first_d = first_q;
      last_d = last_q;
      valid_d = valid_q & ~xfer;
      w_d = w_q;
      w_en_d = '0;
      if (ld) begin
         valid_d = 1'b1;
         data_d = beat;
         first_d = nb_q == '0;
         last_d = nb_q == total - BW'(1);
         nb_d = nb_q + BW'(1);
      end
      if (clr) begin
         data_d = '0;
         first_d = 1'b0;
         last_d = 1'b0;
      end
      case (state_q)
         IDLE: if (cfg_start_i) begin
            state_d = WLOAD;
            len_d = cfg_len_i;
            cnt_d = '0;
            nb_d = '0;
         end
         WLOAD: if (wt.valid) begin
            w_d = wt.data;
            w_en_d = '1;
            cnt_d = cnt_q == CW'(ROW - 1) ? '0 : cnt_q + CW'(1);
            state_d = cnt_q == CW'(ROW - 1) ? WSETTLE : WLOAD;
         end
         WSETTLE: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ROW - 1)) state_d = len_q == '0 ? DONE : STREAM;
         end
         STREAM: state_d = clr ? DONE : STREAM;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         len_q <= '0;
         nb_q <= '0;
         data_q <= '0;
         first_q <= 1'b0;
         last_q <= 1'b0;
         valid_q <= 1'b0;
         w_q <= '0;
         w_en_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         nb_q <= nb_d;
         data_q <= data_d;
         first_q <= first_d;
         last_q <= last_d;
         valid_q <= valid_d;
         w_q <= w_d;
         w_en_q <= w_en_d;
      end
`ifdef MAC_FEEDER_STALL_CNT_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stall_q <= '0;
      else if (state_q == IDLE && cfg_start_i) stall_q <= '0;
      else if (state_q == STREAM && valid_q && !mac_m.ready && ~&stall_q) stall_q <= stall_q + 32'd1;
   assign stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: randomized self-checking bench; expected beats come from the skew rule applied to the sent vectors.
// Build with MAC_FEEDER_STALL_CNT_EN defined to also check the stall counter.
module tb_mac_feeder;
   localparam int DW = 8, WW = 8, ROW = 8, COLUMN = 6, LENW = 16;
   localparam int AW = ROW * DW, WV = COLUMN * WW;
   logic clk = 1'b0, rst_n = 1'b1;
   logic cfg_start = 1'b0;
   logic [LENW-1:0] cfg_len = '0;
   logic busy, done;
   logic [WV-1:0] w;
   logic [COLUMN-1:0] w_en;
`ifdef MAC_FEEDER_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif
   mac_feeder_if #(.W(WV)) wt_if();
   mac_feeder_if #(.W(AW)) act_if();
   mac_feeder_if #(.W(AW)) mac_if();
   mac_feeder #(.DW(DW), .WW(WW), .ROW(ROW), .COLUMN(COLUMN), .LENW(LENW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start_i(cfg_start), .cfg_len_i(cfg_len),
      .busy_o(busy), .done_o(done), .wt(wt_if), .act(act_if), .mac_m(mac_if),
      .w_o(w), .w_en_o(w_en)
`ifdef MAC_FEEDER_STALL_CNT_EN
      , .stall_cnt_o(stall_cnt)
`endif
   );
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0;
   logic [AW-1:0] vecs[$], cap[$], ref8[$];
   logic [WV-1:0] wexp[$];
   int tl = 0, beat_i = 0, wi = 0, cyc = 0, last_wen_cyc = 0, first_rdy_cyc = -1, n_done = 0;
   bit tile_over, stall_prev;
   logic [AW-1:0] hold_d;
   logic hold_f, hold_l;
   task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask
   function automatic int nbeats();
      return tl == 0 ? 0 : tl + ROW - 1;
   endfunction
   // beat b, lane r carries lane r of vector b-r when that vector exists
   function automatic logic [AW-1:0] exp_beat(int b);
      logic [AW-1:0] v, res;
      res = '0;
      for (int r = 0; r < ROW; r++)
         if (b - r >= 0 && b - r < tl) begin
            v = vecs[b-r];
            res[r*DW +: DW] = v[r*DW +: DW];
         end
      return res;
   endfunction
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) stall_prev = 1'b0;
      else begin
         if (stall_prev) begin
            check("stall_valid", mac_if.valid, 1'b1);
            check("stall_data", mac_if.data, hold_d);
            check("stall_first", mac_if.first, hold_f);
            check("stall_last", mac_if.last, hold_l);
         end
         if (mac_if.valid && mac_if.ready) begin
            check("beat_in_range", beat_i < nbeats(), 1'b1);
            check("beat_data", mac_if.data, exp_beat(beat_i));
            check("beat_first", mac_if.first, beat_i == 0);
            check("beat_last", mac_if.last, beat_i == nbeats() - 1);
            cap.push_back(mac_if.data);
            beat_i++;
         end
         stall_prev = mac_if.valid && !mac_if.ready;
         hold_d = mac_if.data;
         hold_f = mac_if.first;
         hold_l = mac_if.last;
         if (w_en != '0) begin
            check("w_en_all", w_en, {COLUMN{1'b1}});
            if (wi < wexp.size()) check("w_data", w, wexp[wi]);
            wi++;
            last_wen_cyc = cyc;
         end
         if (act_if.ready && first_rdy_cyc < 0) first_rdy_cyc = cyc;
         if (done) n_done++;
      end
   end
   task automatic drive_weights(bit glitch);
      int i = 0;
      bit tog = 1'b1, hs;
      for (int c = 0; c < 4000 && i < ROW && !tile_over; c++) begin
         wt_if.valid = tog;
         wt_if.data = wexp[i];
         @(negedge clk);
         hs = wt_if.valid && wt_if.ready;
         @(posedge clk);
         #1;
         if (hs) i++;
         if (glitch) begin
            cfg_start = hs && i == 2;
            cfg_len = 16'd5;
         end
         tog = ~tog;
      end
      wt_if.valid = 1'b0;
      if (glitch) cfg_start = 1'b0;
   endtask
   task automatic drive_acts(int gap_pct);
      int k = 0;
      bit hs;
      for (int c = 0; c < 20000 && k < tl && !tile_over; c++) begin
         act_if.valid = $urandom_range(99) >= gap_pct;
         act_if.data = vecs[k];
         @(negedge clk);
         hs = act_if.valid && act_if.ready;
         @(posedge clk);
         #1;
         if (hs) k++;
      end
      act_if.valid = 1'b0;
   endtask
   task automatic drive_ready(int mode);
      int stalled = 0;
      for (int c = 0; c < 20000 && !tile_over; c++) begin
         if (mode == 2 && beat_i == 2 && stalled < 5) begin
            mac_if.ready = 1'b0;
            stalled++;
         end else mac_if.ready = mode == 1 ? 1'($urandom_range(1)) : 1'b1;
         @(posedge clk);
         #1;
      end
      mac_if.ready = 1'b1;
   endtask
   task automatic wait_done(int budget, output bit got);
      got = 1'b0;
      for (int c = 0; c < budget && !got; c++) begin
         @(negedge clk);
         got = done;
      end
      tile_over = 1'b1;
   endtask
   task automatic setup(int L, bit rnd);
      logic [AW-1:0] v;
      vecs.delete();
      wexp.delete();
      cap.delete();
      for (int k = 0; k < L; k++) begin
         for (int r = 0; r < ROW; r++) v[r*DW +: DW] = 8'(16 * k + r + 1);
         vecs.push_back(rnd ? AW'({$urandom, $urandom}) : v);
      end
      for (int i = 0; i < ROW; i++) wexp.push_back(rnd ? WV'({$urandom, $urandom}) : WV'(8'h11 * (i + 1)));
      tl = L;
      beat_i = 0;
      wi = 0;
      first_rdy_cyc = -1;
      tile_over = 1'b0;
      cfg_len = LENW'(L);
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
   endtask
   task automatic run_tile(int L, int gap, int rmode, bit glitch, bit rnd);
      bit got;
      int nd0 = n_done;
      setup(L, rnd);
      fork
         drive_weights(glitch);
         drive_acts(gap);
         drive_ready(rmode);
         wait_done(40 * (L + 3 * ROW) + 200, got);
      join
      check("done_seen", got, 1'b1);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("idle_not_busy", busy, 1'b0);
      check("beat_count", beat_i, nbeats());
      check("w_en_count", wi, ROW);
      check("done_count", n_done - nd0, 1);
      if (L > 0) check("settle_cycles", first_rdy_cyc - last_wen_cyc, ROW);
   endtask
   task automatic check_quiet(string nm);
      check({nm, "_ctrl"}, {mac_if.valid, mac_if.first, mac_if.last, busy, done, act_if.ready, wt_if.ready}, 7'd0);
      check({nm, "_data"}, mac_if.data, '0);
      check({nm, "_w"}, {w, w_en}, '0);
   endtask
   task automatic reset_mid_stream();
      int nd0 = n_done;
      setup(16, 1'b0);
      fork
         drive_weights(1'b0);
         drive_acts(0);
         drive_ready(0);
         begin
            for (int c = 0; c < 2000 && beat_i < 3; c++) @(negedge clk);
            check("reached_beat3", beat_i, 3);
            #1 rst_n = 1'b0;
            #1 check_quiet("async_reset");
            tile_over = 1'b1;
         end
      join
      repeat (3) @(negedge clk);
      check_quiet("held_reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_quiet("after_reset");
      check("no_done_on_abort", n_done - nd0, 0);
   endtask
   initial begin
      logic [AW-1:0] b;
      wt_if.valid = 1'b0;
      wt_if.data = '0;
      wt_if.first = 1'b0;
      wt_if.last = 1'b0;
      act_if.valid = 1'b0;
      act_if.data = '0;
      act_if.first = 1'b0;
      act_if.last = 1'b0;
      mac_if.ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet("reset_state");
      @(posedge clk);
      #1 rst_n = 1'b1;
      // L=4 full rate with the 16k+r+1 pattern, pinned against hand-computed beats
      run_tile(4, 0, 0, 1'b0, 1'b0);
      check("model_beat0", exp_beat(0), 64'h01);
      check("model_beat10", exp_beat(10), 64'h3800_0000_0000_0000);
      check("cap_size_L4", cap.size(), 11);
      b = cap[0];
      check("beat0_literal", b, 64'h0000_0000_0000_0001);
      b = cap[3];
      check("beat3_lane3", b[3*DW +: DW], 8'h04);
      b = cap[10];
      check("beat10_literal", b, 64'h3800_0000_0000_0000);
      run_tile(8, 0, 0, 1'b0, 1'b0);
      ref8 = cap;
      run_tile(8, 0, 1, 1'b0, 1'b0);
      check("bp_beats", cap.size(), 15);
      for (int i = 0; i < 15 && i < cap.size() && i < ref8.size(); i++) check("bp_same_seq", cap[i], ref8[i]);
      run_tile(0, 0, 0, 1'b1, 1'b0);
      reset_mid_stream();
      run_tile(16, 0, 0, 1'b0, 1'b0);
      run_tile(1, 0, 1, 1'b0, 1'b1);
      for (int t = 0; t < 5; t++) run_tile($urandom_range(40, 1), $urandom_range(50), 1, 1'b0, 1'b1);
      run_tile(120, 20, 1, 1'b0, 1'b1);
`ifdef MAC_FEEDER_STALL_CNT_EN
      run_tile(4, 0, 2, 1'b0, 1'b0);
      check("stall_cnt", stall_cnt, 32'd5);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Producer side of the systolic MAC array input interface.
- Per tile it does two things:
  - Loads ROW weight vectors into the array weight pipeline on w/w_en.
  - Then streams an activation tile of cfg_len ROW-lane vectors onto mac_m_* with first/last/valid/ready. Lane r is diagonally skewed by r beats, so each array row sees its operand aligned with the partial sum arriving from the row above.
- Sits between the activation/weight buffers and the MAC array.

Parameters:
- DW, 8, activation lane width
- WW, 8, weight width
- ROW, 8, array rows (activation lanes); must be >= 2
- COLUMN, 6, array columns
- LENW, 16, width of tile length field

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cfg_start  in  1  start a tile; sampled only in IDLE
- cfg_len  in  LENW  activation vectors in tile; captured on accepted cfg_start
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at tile end
- wt_data  in  COLUMN*WW  weight vector
- wt_valid  in  1  weight valid
- wt_ready  out  1  weight ready
- act_data  in  ROW*DW  activation vector, lane r at [r*DW +: DW]
- act_valid  in  1  activation valid
- act_ready  out  1  activation ready
- mac_m_data  out  ROW*DW  skewed activation beat
- mac_m_first  out  1  first beat of tile
- mac_m_last  out  1  last beat of tile
- mac_m_valid  out  1  beat valid
- mac_m_ready  in  1  array ready
- w  out  COLUMN*WW  weight into array row 0 pipeline
- w_en  out  COLUMN  per-column weight load strobe

Behaviour:
- Reset and clocking: rst_n is asynchronous, active-low; clk is the clock. Every output resets to 0; the FSM resets to IDLE.
- IDLE → WLOAD:
  - Taken when cfg_start=1; cfg_len is latched.
  - cfg_start in any other state is ignored.
- WLOAD:
  - wt_ready=1.
  - On each wt handshake, w=wt_data registered and w_en=all-ones for exactly that cycle. Otherwise w holds its last value and w_en=0.
  - Vector order is array row ROW-1 first, row 0 last.
  - After the ROW-th handshake → WSETTLE.
- WSETTLE:
  - Counts ROW cycles with w_en=0 so the last weight reaches its row.
  - If latched len==0 → DONE; else → STREAM.
- STREAM:
  - Tile of L=len vectors emits exactly L+ROW-1 beats, b=0..L+ROW-2.
  - Beat b lane r = lane r of input vector (b-r) if 0<=b-r<L, else 0.
  - mac_m_first=1 only on b=0; mac_m_last=1 only on b=L+ROW-2. With L=1 both fall on different beats (0 and ROW-1).
- Beat validity:
  - For b<L, beat b is valid once vector b has been accepted.
  - Drain beats b>=L are always valid.
  - act_ready=1 only in STREAM while accepted<L and the output register is empty or being consumed that cycle.
  - Latency: activation accepted in cycle t → its lane-0 data on mac_m_data in cycle t+1.
- Handshake rules:
  - A beat transfers on mac_m_valid & mac_m_ready.
  - While valid & !ready, mac_m_data, first and last hold stable.
  - Skew delay lines advance only on a transfer, never on stalls or input bubbles.
  - mac_m_valid never drops without a transfer.
- Leaving STREAM: after the last-beat transfer → DONE, and the skew lines are cleared to 0.
- DONE: done=1 for one cycle → IDLE.
- Boundary cases:
  - Simultaneous act accept and mac_m transfer in the same cycle is supported: full throughput of 1 beat/cycle.
  - Asynchronous reset mid-tile aborts immediately: outputs 0, no done pulse.
  - cfg_len at maximum (2^LENW-1): the beat counter is LENW+clog2(ROW)+1 bits, so there is no wrap.

Optional Feature:
- Macro MAC_FEEDER_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[31:0].
  - Counts cycles in STREAM with mac_m_valid & !mac_m_ready.
  - Cleared on accepted cfg_start, saturates at all-ones, holds after done.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-STREAM: assert rst_n=0 at beat 3 of L=16 → all outputs 0 within the reset cycle, FSM IDLE, no done; next cfg_start runs a clean tile.
- Weight load, ROW=8, wt_valid toggling 1/0:
  - 8 weights 0x11..0x88 sent → w_en all-ones on exactly 8 cycles, w sequence 0x11..0x88.
  - 8 settle cycles follow, then STREAM.
- Tile L=4 at full rate, mac_m_ready=1, lane r of vector k = 16*k+r+1:
  - 11 beats total; beat 0 = {0,...,0,0x01}, beat 3 lane 3 = 0x04.
  - beat 10 = only lane 7 nonzero (0x38); first on beat 0, last on beat 10; done one cycle later.
- Backpressure, L=8, mac_m_ready random 50%:
  - mac_m_data/first/last stable during every stall.
  - Captured beat sequence identical to the full-rate run: 15 beats.
- cfg_len=0: 8 weight loads → no mac_m_valid ever, done after WSETTLE; cfg_start pulsed during WLOAD is ignored.
- With MAC_FEEDER_STALL_CNT_EN, L=4, ready held low for 5 cycles at beat 2 → stall_cnt=5 after done.
